// File: rtl/cpu_bus_unit.sv
// rtl/cpu_bus_unit.sv - stalling load/store bus unit with memory and IO channels
module cpu_bus_unit #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                IO_W      = 16,
    parameter int                NUM_IO    = 4,
    parameter logic [ADDR_W-1:0] IO_BASE   = 32'hFFFFFC00,
    parameter int                IO_STRIDE = 16,
    parameter int                TIMEOUT   = 255
) (
    input  logic                         iCpuClock,
    input  logic                         iCpuResetN,
    input  logic                         iReq,
    input  logic                         iWrite,
    input  logic [1:0]                   iSize,
    input  logic                         iSignedLoad,
    input  logic [ADDR_W-1:0]            iAddr,
    input  logic [DATA_W-1:0]            iWData,
    output logic                         oStall,
    output logic                         oDone,
    output logic [DATA_W-1:0]            oRData,
    output logic                         oFault,
    output logic                         oMemReq,
    output logic                         oMemWe,
    output logic [ADDR_W-1:0]            oMemAddr,
    output logic [3:0]                   oMemByteEn,
    output logic [DATA_W-1:0]            oMemWData,
    input  logic                         iMemAck,
    input  logic [DATA_W-1:0]            iMemRData,
    output logic [NUM_IO-1:0]            oIoSel,
    output logic                         oIoWe,
    output logic [$clog2(IO_STRIDE)-1:0] oIoOffset,
    output logic [IO_W-1:0]              oIoWData,
    input  logic                         iIoAck,
    input  logic [NUM_IO*IO_W-1:0]       iIoRData
);
    localparam int OFF_W = $clog2(IO_STRIDE);
    localparam int CH_W  = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MEM  = 2'd1;
    localparam logic [1:0] S_IO   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        r_state;
    logic [15:0]       r_cnt;
    logic [1:0]        r_lane;
    logic [1:0]        r_size;
    logic              r_signed;
    logic              r_write;
    logic [CH_W-1:0]   r_ch;
    logic              r_done;
    logic              r_fault;
    logic [DATA_W-1:0] r_rdata;

    logic              w_in_io;
    logic [ADDR_W-1:0] w_io_idx;
    logic              w_fault;
    logic [DATA_W-1:0] w_st_data;
    logic [3:0]        w_st_be;
    logic [7:0]        w_mem_byte;
    logic [15:0]       w_mem_half;
    logic [DATA_W-1:0] w_mem_raw;
    logic [IO_W-1:0]   w_io_word;
    logic              w_ack;

    function automatic logic [DATA_W-1:0] f_extend(input logic [DATA_W-1:0] raw,
                                                   input logic [1:0] size, input logic sgn);
        case (size)
            2'b00:   f_extend = {{(DATA_W-8){sgn & raw[7]}}, raw[7:0]};
            2'b01:   f_extend = {{(DATA_W-16){sgn & raw[15]}}, raw[15:0]};
            default: f_extend = raw;
        endcase
    endfunction

    // Anything at or above IO_BASE is IO; channels past NUM_IO are unmapped holes.
    assign w_in_io  = iAddr >= IO_BASE;
    assign w_io_idx = (iAddr - IO_BASE) >> OFF_W;
    assign w_fault  = (iSize == 2'b11)
                    | ((iSize == 2'b01) & iAddr[0])
                    | ((iSize == 2'b10) & (|iAddr[1:0]))
                    | (w_in_io & (w_io_idx >= ADDR_W'(NUM_IO)));

    always_comb begin
        w_st_data = iWData;
        w_st_be   = 4'b1111;
        case (iSize)
            2'b00: begin
                w_st_data = {4{iWData[7:0]}};
                w_st_be   = 4'b0001 << iAddr[1:0];
            end
            2'b01: begin
                w_st_data = {2{iWData[15:0]}};
                w_st_be   = iAddr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
        if (!iWrite) w_st_be = 4'b0000;
    end

    assign w_mem_byte = iMemRData[{r_lane, 3'b000} +: 8];
    assign w_mem_half = r_lane[1] ? iMemRData[31:16] : iMemRData[15:0];
    assign w_mem_raw  = (r_size == 2'b00) ? DATA_W'(w_mem_byte) :
                        (r_size == 2'b01) ? DATA_W'(w_mem_half) : iMemRData;
    assign w_io_word  = iIoRData[int'(r_ch)*IO_W +: IO_W];
    assign w_ack      = (r_state == S_MEM) ? iMemAck : iIoAck;

    always_ff @(posedge iCpuClock or negedge iCpuResetN) begin
        if (!iCpuResetN) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_lane     <= '0;
            r_size     <= '0;
            r_signed   <= 1'b0;
            r_write    <= 1'b0;
            r_ch       <= '0;
            r_done     <= 1'b0;
            r_fault    <= 1'b0;
            r_rdata    <= '0;
            oMemReq    <= 1'b0;
            oMemWe     <= 1'b0;
            oMemAddr   <= '0;
            oMemByteEn <= '0;
            oMemWData  <= '0;
            oIoSel     <= '0;
            oIoWe      <= 1'b0;
            oIoOffset  <= '0;
            oIoWData   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (iReq) begin
                    r_lane   <= iAddr[1:0];
                    r_size   <= iSize;
                    r_signed <= iSignedLoad;
                    r_write  <= iWrite;
                    r_cnt    <= '0;
                    if (w_fault) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_fault <= 1'b1;
                        r_rdata <= '0;
                    end else if (w_in_io) begin
                        r_state   <= S_IO;
                        r_ch      <= w_io_idx[CH_W-1:0];
                        oIoSel    <= NUM_IO'(1) << w_io_idx[CH_W-1:0];
                        oIoWe     <= iWrite;
                        oIoOffset <= iAddr[OFF_W-1:0];
                        oIoWData  <= iWData[IO_W-1:0];
                    end else begin
                        r_state    <= S_MEM;
                        oMemReq    <= 1'b1;
                        oMemWe     <= iWrite;
                        oMemAddr   <= {iAddr[ADDR_W-1:2], 2'b00};
                        oMemByteEn <= w_st_be;
                        oMemWData  <= w_st_data;
                    end
                end
                S_MEM, S_IO: begin
                    // An ack on the final counted cycle takes priority over the timeout.
                    if (w_ack || (r_cnt == 16'(TIMEOUT - 1))) begin
                        r_state    <= S_DONE;
                        r_done     <= 1'b1;
                        r_fault    <= ~w_ack;
                        if (!w_ack || r_write)
                            r_rdata <= '0;
                        else if (r_state == S_MEM)
                            r_rdata <= f_extend(w_mem_raw, r_size, r_signed);
                        else
                            r_rdata <= f_extend(DATA_W'(w_io_word), r_size, r_signed);
                        oMemReq    <= 1'b0;
                        oMemWe     <= 1'b0;
                        oMemAddr   <= '0;
                        oMemByteEn <= '0;
                        oMemWData  <= '0;
                        oIoSel     <= '0;
                        oIoWe      <= 1'b0;
                        oIoOffset  <= '0;
                        oIoWData   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_fault <= 1'b0;
                    r_rdata <= '0;
                end
            endcase
        end
    end

    assign oDone  = r_done;
    assign oFault = r_fault;
    assign oRData = r_rdata;
    assign oStall = iReq & iCpuResetN & (r_state != S_DONE);
endmodule

// File: tb/tb_cpu_bus_unit.sv
// tb/tb_cpu_bus_unit.sv - scoreboard bench for cpu_bus_unit
module tb_cpu_bus_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iReq = 1'b0, iWrite = 1'b0, iSignedLoad = 1'b0;
    logic [1:0]  iSize = 2'b10;
    logic [31:0] iAddr = '0, iWData = '0;
    logic        oStall, oDone, oFault, oMemReq, oMemWe, oIoWe;
    logic [31:0] oRData, oMemAddr, oMemWData;
    logic [3:0]  oMemByteEn, oIoSel, oIoOffset;
    logic [15:0] oIoWData;
    logic        iMemAck = 1'b0, iIoAck = 1'b0;
    logic [31:0] iMemRData = '0;
    logic [63:0] iIoRData = {16'h3333, 16'h2222, 16'h8001, 16'h1111};

    always #5 clk = ~clk;

    cpu_bus_unit #(.TIMEOUT(8)) dut (
        .iCpuClock(clk), .iCpuResetN(rst_n), .iReq(iReq), .iWrite(iWrite),
        .iSize(iSize), .iSignedLoad(iSignedLoad), .iAddr(iAddr), .iWData(iWData),
        .oStall(oStall), .oDone(oDone), .oRData(oRData), .oFault(oFault),
        .oMemReq(oMemReq), .oMemWe(oMemWe), .oMemAddr(oMemAddr),
        .oMemByteEn(oMemByteEn), .oMemWData(oMemWData), .iMemAck(iMemAck),
        .iMemRData(iMemRData), .oIoSel(oIoSel), .oIoWe(oIoWe),
        .oIoOffset(oIoOffset), .oIoWData(oIoWData), .iIoAck(iIoAck),
        .iIoRData(iIoRData)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        fault;
        logic [7:0]  lat;
    } exp_t;
    exp_t sb_q[$];

    int n_chk = 0, n_fail = 0;
    int g_mem_wait = 0, g_io_wait = 0, mem_cnt = 0, io_cnt = 0, mem_cycles = 0, io_cycles = 0;
    logic [31:0] s_mem_addr, s_mem_wdata;
    logic [3:0]  s_be, s_iosel, s_off;
    logic        s_we, s_iowe;
    logic [15:0] s_iowd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory and IO responders: ack after a programmed number of wait cycles.
    always @(negedge clk) begin
        if (oMemReq) begin
            if (mem_cnt == 0) begin
                s_mem_addr = oMemAddr; s_mem_wdata = oMemWData; s_be = oMemByteEn; s_we = oMemWe;
            end
            iMemAck = (mem_cnt == g_mem_wait);
            mem_cnt++;
            mem_cycles++;
        end else begin
            iMemAck = 1'b0;
            mem_cnt = 0;
        end
        if (|oIoSel) begin
            if (io_cnt == 0) begin
                s_iosel = oIoSel; s_off = oIoOffset; s_iowd = oIoWData; s_iowe = oIoWe;
            end
            iIoAck = (io_cnt == g_io_wait);
            io_cnt++;
            io_cycles++;
        end else begin
            iIoAck = 1'b0;
            io_cnt = 0;
        end
    end

    task automatic access(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_f, input int exp_lat);
        exp_t e;
        int lat;
        bit seen;
        sb_q.push_back('{rdata: exp_rd, fault: exp_f, lat: 8'(exp_lat)});
        @(negedge clk);
        mem_cycles = 0;
        io_cycles  = 0;
        iReq = 1'b1; iWrite = we; iSize = sz; iSignedLoad = sg; iAddr = addr; iWData = wd;
        lat = 0;
        seen = 0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (oDone) seen = 1;
        end
        e = sb_q.pop_front();
        check("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("rdata", oRData, e.rdata);
            check("fault", 32'(oFault), 32'(e.fault));
            check("latency", lat, 32'(e.lat));
            check("stall_at_done", 32'(oStall), 32'd0);
        end
        iReq = 1'b0;
    endtask

    initial begin
        bit any_done;
        iReq = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_stall", 32'(oStall), 32'd0);
        check("rst_done", 32'(oDone), 32'd0);
        check("rst_memreq", 32'(oMemReq), 32'd0);
        check("rst_iosel", 32'(oIoSel), 32'd0);
        check("rst_rdata", oRData, 32'd0);
        iReq = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        g_mem_wait = 3;
        iMemRData = 32'hDEADBEEF;
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5);
        check("word_memreq_cycles", mem_cycles, 32'd4);
        check("word_addr", s_mem_addr, 32'h10);
        check("word_be_load", 32'(s_be), 32'd0);

        g_mem_wait = 0;
        iMemRData = 32'h80FF1234;
        access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 2);
        access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h00000080, 1'b0, 2);
        check("byte_addr_aligned", s_mem_addr, 32'h10);
        access(1'b0, 2'b01, 1'b0, 32'h02, 32'h0, 32'h000080FF, 1'b0, 2);
        access(1'b0, 2'b01, 1'b1, 32'h02, 32'h0, 32'hFFFF80FF, 1'b0, 2);
        access(1'b0, 2'b01, 1'b1, 32'h00, 32'h0, 32'h00001234, 1'b0, 2);

        g_mem_wait = 1;
        access(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000ABCD, 32'h0, 1'b0, 3);
        check("half_be", 32'(s_be), 32'b1100);
        check("half_wdata", s_mem_wdata, 32'hABCDABCD);
        check("half_addr", s_mem_addr, 32'h20);
        check("half_we", 32'(s_we), 32'd1);
        access(1'b1, 2'b00, 1'b0, 32'h01, 32'h0000005A, 32'h0, 1'b0, 3);
        check("byte_be", 32'(s_be), 32'b0010);
        check("byte_wdata", s_mem_wdata, 32'h5A5A5A5A);

        g_io_wait = 0;
        access(1'b0, 2'b01, 1'b1, 32'hFFFFFC14, 32'h0, 32'hFFFF8001, 1'b0, 2);
        check("io_sel", 32'(s_iosel), 32'b0010);
        check("io_off", 32'(s_off), 32'd4);
        check("io_memreq_idle", mem_cycles, 32'd0);
        g_io_wait = 2;
        access(1'b1, 2'b10, 1'b0, 32'hFFFFFC38, 32'h1234BEEF, 32'h0, 1'b0, 4);
        check("io_st_sel", 32'(s_iosel), 32'b1000);
        check("io_st_off", 32'(s_off), 32'd8);
        check("io_st_wdata", 32'(s_iowd), 32'h0000BEEF);
        check("io_st_we", 32'(s_iowe), 32'd1);
        check("io_st_cycles", io_cycles, 32'd3);

        access(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1, 1);
        check("mis_no_bus", mem_cycles + io_cycles, 32'd0);
        access(1'b0, 2'b10, 1'b0, 32'hFFFFFC40, 32'h0, 32'h0, 1'b1, 1);
        check("unmapped_no_bus", mem_cycles + io_cycles, 32'd0);
        access(1'b1, 2'b11, 1'b0, 32'h00, 32'h0, 32'h0, 1'b1, 1);
        access(1'b0, 2'b01, 1'b0, 32'h01, 32'h0, 32'h0, 1'b1, 1);

        g_mem_wait = 1000;
        access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 9);
        check("timeout_memreq_cycles", mem_cycles, 32'd8);

        @(negedge clk);
        iReq = 1'b1; iWrite = 1'b0; iSize = 2'b10; iAddr = 32'h44;
        repeat (3) @(negedge clk);
        check("mid_memreq", 32'(oMemReq), 32'd1);
        #1 rst_n = 1'b0;
        #1 check("rst_mid_memreq", 32'(oMemReq), 32'd0);
        check("rst_mid_stall", 32'(oStall), 32'd0);
        any_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (oDone) any_done = 1;
        end
        check("rst_mid_no_done", 32'(any_done), 32'd0);
        iReq = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_bus_unit.md
# cpu_bus_unit

Parametrised load/store bus unit between the CPU core and the data-side world: it replaces the single-cycle, always-ready memory/switch/LED/tube path with a stalling, handshaked access engine. It decodes each access to data memory or to one of NUM_IO peripheral channels, drives a req/ack transaction with timeout, handles byte/halfword/word size with lane steering and sign extension, and stalls the core until the access completes.

## Interface
- DATA_W, 32, CPU data and memory data width (multiple of 8, fixed lane logic assumes 32)
- ADDR_W, 32, CPU address width
- IO_W, 16, peripheral data width
- NUM_IO, 4, peripheral channel count (1..8)
- IO_BASE, 32'hFFFFFC00, first byte address of the IO region
- IO_STRIDE, 16, bytes per channel (power of two, ≥4)
- TIMEOUT, 255, max wait cycles for ack (1..65535)

- iCpuClock  in  1  clock, all state on rising edge
- iCpuResetN  in  1  reset, asynchronous, active-low
- iReq  in  1  core access request, held until oDone
- iWrite  in  1  1 = store, 0 = load
- iSize  in  2  00 byte, 01 halfword, 10 word; 11 treated as fault
- iSignedLoad  in  1  sign-extend byte/half loads
- iAddr  in  ADDR_W  byte address
- iWData  in  DATA_W  store data (right-aligned)
- oStall  out  1  core must hold PC/state
- oDone  out  1  one-cycle completion pulse
- oRData  out  DATA_W  load result, valid while oDone
- oFault  out  1  with oDone: misaligned, bad size, unmapped IO, or timeout
- oMemReq  out  1  memory transaction active
- oMemWe  out  1  memory write
- oMemAddr  out  ADDR_W  word-aligned address (addr[1:0]=0)
- oMemByteEn  out  4  write lane enables
- oMemWData  out  DATA_W  lane-replicated store data
- iMemAck  in  1  memory completion
- iMemRData  in  DATA_W  memory read word, valid with iMemAck
- oIoSel  out  NUM_IO  one-hot channel select
- oIoWe  out  1  peripheral write
- oIoOffset  out  $clog2(IO_STRIDE)  byte offset within channel
- oIoWData  out  IO_W  iWData[IO_W-1:0]
- iIoAck  in  1  peripheral completion (OR of channels)
- iIoRData  in  NUM_IO*IO_W  per-channel read data, channel k at [k*IO_W +: IO_W]

## Operation
- States: IDLE, MEM, IO, DONE.
- IDLE, iReq=1: latch addr/data/size/write/signed; classify:
  - fault if iSize=11, half with addr[0]≠0, word with addr[1:0]≠0, or addr in IO region with channel index ≥ NUM_IO (region = [IO_BASE, IO_BASE+2^ceil-aligned span)); go DONE with fault, no bus activity.
  - addr ≥ IO_BASE → IO, channel = (addr−IO_BASE)/IO_STRIDE; else → MEM.
- MEM: oMemReq=1, oMemWe=write, oMemAddr=addr & ~3. Store: byte → data[7:0] replicated ×4, byteEn=1<<addr[1:0]; half → data[15:0] ×2, byteEn=addr[1]?1100:0011; word → 1111. Load: byteEn=0000. On iMemAck: capture lane-selected data → DONE.
- IO: oIoSel one-hot, oIoWe=write, oIoOffset=addr low bits. On iIoAck: capture iIoRData of selected channel, extend to DATA_W (sign if iSignedLoad and size≠word) → DONE.
- Load extension: byte lane addr[1:0], half lane addr[1]; zero-extend unless iSignedLoad; word unchanged.
- Wait counter clears on entering MEM/IO, increments each non-ack cycle; reaching TIMEOUT → drop strobes, DONE with fault, oRData=0.
- DONE: oDone=1, oRData/oFault valid (oRData=0 for stores and faults); next state IDLE unconditionally.
- oStall = iReq & ~(state==DONE) (combinational); core advances on the DONE cycle.

## Timing
- Reset (async, iCpuResetN=0): state IDLE, counter 0, all outputs 0 (oStall follows iReq only after reset release; held 0 during reset).
- Reset mid-transaction: strobes drop immediately; no oDone issued.
- Bus strobes, oDone, oRData, oFault are registered.
- Latency (iReq to oDone): fault in IDLE = 1 cycle (DONE next edge); ack in first MEM/IO cycle = 2 cycles; ack after n wait cycles = 2+n; timeout = TIMEOUT+1.
- Ack sampled only in MEM/IO; acks in IDLE/DONE ignored. Ack on the same cycle counter hits TIMEOUT: ack wins, no fault.
- iReq high on the cycle after DONE starts a new access (back-to-back, one IDLE cycle).
- Strobes constant for the whole MEM/IO state.

## Test plan
- Word load 0x00000010, memory ack after 3 wait cycles, iMemRData=0xDEADBEEF -> oMemReq 4 cycles, oDone 5 cycles after iReq, oRData=0xDEADBEEF, oFault=0.
- Signed byte load 0x00000013, iMemRData=0x80FF1234 -> oRData=0xFFFFFF80; same unsigned -> 0x00000080.
- Half store 0x00000022 data 0x0000ABCD -> oMemByteEn=1100, oMemWData=0xABCDABCD, oMemAddr=0x20.
- IO load 0xFFFFFC14 (channel 1, offset 4), signed half, iIoRData ch1=0x8001 -> oIoSel=0010, oRData=0xFFFF8001.
- Word at 0x00000006 and IO 0xFFFFFC40 (channel 4 with NUM_IO=4) -> no strobes, oDone after 1 cycle, oFault=1, oRData=0.
- Memory never acks, TIMEOUT=8 -> oMemReq 8 cycles then oDone+oFault; separate run asserts iCpuResetN=0 mid-MEM -> oMemReq=0 immediately, no oDone.
